// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types and constants for the register-bus arbiter: FSM states,
// register address map and a small width helper.
package reg_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [7:0] REG_ADDR_ID     = 8'h00;
  localparam logic [7:0] REG_ADDR_STATUS = 8'h01;
  localparam logic [7:0] REG_ADDR_LED    = 8'h10;

  localparam logic [7:0] ERR_COUNT_MAX   = 8'hFF;

  // Bits needed to index n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first active request at or after the
// pointer (wrapping) wins and is returned both one-hot and as an index.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int j;

  // Walk offsets from farthest to nearest so the nearest active request is the last write.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int off = N - 1; off >= 0; off--) begin
      j = (int'(ptr_i) + off) % N;
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares one register-file port between NUM_REQ requesters: round-robin grant,
// one outstanding transaction, optional lock, and a completion timeout.
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ-1:0]        req_lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      bus_valid_o,
  output logic                      bus_we_o,
  output logic [ADDR_W-1:0]         bus_addr_o,
  output logic [DATA_W-1:0]         bus_wdata_o,
  input  logic                      bus_ack_i,
  input  logic [DATA_W-1:0]         bus_rdata_i,
  output logic                      busy_o,
  output logic [7:0]                err_count_o
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = idx_width(TIMEOUT_CYC);
  localparam int TO_LAST_INT = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_INT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    widx_q, widx_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    lock_own_q, lock_own_d;
  logic                lock_vld_q, lock_vld_d;
  logic                lk_q, lk_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    tcnt_q, tcnt_d;
  logic [7:0]          errcnt_q, errcnt_d;

  logic [NUM_REQ-1:0]  lock_mask;
  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  // While a lock is held and its owner still requests, only the owner may compete.
  always_comb begin
    lock_mask             = '0;
    lock_mask[lock_own_q] = 1'b1;
    arb_req               = (lock_vld_q && req_valid_i[lock_own_q]) ? lock_mask : req_valid_i;
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i (arb_req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      widx_q     <= '0;
      ptr_q      <= '0;
      lock_own_q <= '0;
      lock_vld_q <= 1'b0;
      lk_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      tcnt_q     <= '0;
      errcnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      widx_q     <= widx_d;
      ptr_q      <= ptr_d;
      lock_own_q <= lock_own_d;
      lock_vld_q <= lock_vld_d;
      lk_q       <= lk_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      tcnt_q     <= tcnt_d;
      errcnt_q   <= errcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    widx_d      = widx_q;
    ptr_d       = ptr_q;
    lock_own_d  = lock_own_q;
    lock_vld_d  = lock_vld_q;
    lk_d        = lk_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    tcnt_d      = tcnt_q;
    errcnt_d    = errcnt_q;
    req_ready_o = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (lock_vld_q && !req_valid_i[lock_own_q]) begin
          lock_vld_d = 1'b0;
        end
        if (arb_any) begin
          req_ready_o = arb_gnt;
          grant_d     = arb_gnt;
          widx_d      = arb_idx;
          we_d        = req_we_i[arb_idx];
          lk_d        = req_lock_i[arb_idx];
          addr_d      = req_addr_i[arb_idx*ADDR_W +: ADDR_W];
          wdata_d     = req_wdata_i[arb_idx*DATA_W +: DATA_W];
          tcnt_d      = '0;
          state_d     = ST_BUSY;
        end
      end

      // An ack on the final allowed cycle takes priority over the timeout.
      ST_BUSY: begin
        if (bus_ack_i) begin
          rdata_d = bus_rdata_i;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (TIMEOUT_CYC != 0 && tcnt_q == TO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          if (errcnt_q != ERR_COUNT_MAX) begin
            errcnt_d = errcnt_q + 8'd1;
          end
          state_d = ST_RESP;
        end else if (TIMEOUT_CYC != 0) begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        ptr_d      = (widx_q == IDX_LAST) ? '0 : widx_q + IDX_W'(1);
        lock_own_d = widx_q;
        lock_vld_d = lk_q;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_valid_o = (state_q == ST_RESP) ? grant_q : '0;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign bus_valid_o = (state_q == ST_BUSY);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign err_count_o = errcnt_q;

endmodule
